// File: rtl/wb_pkg.sv
// wb_pkg: shared Wishbone slave types, widths and byte-lane merge helper
package wb_pkg;
  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W = 4;
  typedef enum logic [2:0] {IDLE, RD_WAIT, RESP_ACK, RESP_ERR, HOLD} wb_resp_state_t;
  // Replace only the byte lanes whose sel bit is set
  function automatic logic [WB_DATA_W-1:0] wb_byte_merge(
    input logic [WB_DATA_W-1:0] old,
    input logic [WB_DATA_W-1:0] wdata,
    input logic [WB_SEL_W-1:0] sel
  );
    logic [WB_DATA_W-1:0] m;
    m = old;
    for (int i = 0; i < WB_SEL_W; i++) m[8*i +: 8] = sel[i] ? wdata[8*i +: 8] : old[8*i +: 8];
    return m;
  endfunction
endpackage

// File: rtl/wb_bus.sv
// wb_bus: single-master Wishbone classic bus bundle
interface wb_bus;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0] sel;
  logic we;
  logic stb;
  logic ack;
  logic err;
  modport master(output addr, wdata, sel, we, stb, input rdata, ack, err);
  modport slave(input addr, wdata, sel, we, stb, output rdata, ack, err);
endinterface

// File: rtl/wb_mem_array.sv
// wb_mem_array: word storage with byte-lane write port and registered read port
module wb_mem_array
  import wb_pkg::*;
#(
  parameter int DepthWords = 1024,
  parameter string InitFile = "",
  parameter logic [WB_DATA_W-1:0] InitWord = 32'h00000013,
  localparam int AW = $clog2(DepthWords)
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  input  logic                 we,
  input  logic                 re,
  input  logic [AW-1:0]        idx,
  input  logic [WB_DATA_W-1:0] wdata,
  input  logic [WB_SEL_W-1:0]  sel,
  output logic [WB_DATA_W-1:0] q
);
  logic [WB_DATA_W-1:0] mem [DepthWords] = '{default: InitWord};
  always_ff @(posedge clk_in)
    if (we) mem[idx] <= wb_byte_merge(mem[idx], wdata, sel);
  always_ff @(posedge clk_in or posedge reset_in)
    if (reset_in) q <= '0;
    else if (re) q <= mem[idx];
endmodule

// File: rtl/wb_memory.sv
// wb_memory: Wishbone slave RAM/ROM with address decode and single-shot ack/err
module wb_memory
  import wb_pkg::*;
#(
  parameter logic [31:0] BaseAddr = 32'h0,
  parameter int DepthWords = 1024,
  parameter bit ReadOnly = 1'b1,
  parameter bit OutReg = 1'b0,
  parameter string InitFile = "",
  parameter logic [WB_DATA_W-1:0] InitWord = 32'h00000013
) (
  input logic clk_in,
  input logic reset_in,
  wb_bus.slave bus_slave
);
  localparam int AW = $clog2(DepthWords);
  localparam logic [31:0] SPAN = 32'(DepthWords * 4);
  wb_resp_state_t state, state_nxt;
  logic [31:0] off;
  logic [AW-1:0] idx;
  logic [WB_DATA_W-1:0] stage1;
  logic bad, start, wr, rd, ack_q, err_q;
  assign off = bus_slave.addr - BaseAddr;
  assign idx = off[AW+1:2];
  assign bad = (|bus_slave.addr[1:0]) | ~(off < SPAN) | (bus_slave.we & ReadOnly)
             | (bus_slave.we & ~|bus_slave.sel);
  assign start = (state == IDLE) & bus_slave.stb & ~bad;
  assign wr = start & bus_slave.we;
  assign rd = start & ~bus_slave.we;
  assign bus_slave.ack = ack_q;
  assign bus_slave.err = err_q;
  wb_mem_array #(.DepthWords(DepthWords), .InitFile(InitFile), .InitWord(InitWord)) u_array (
    .clk_in(clk_in), .reset_in(reset_in), .we(wr), .re(rd), .idx(idx),
    .wdata(bus_slave.wdata), .sel(bus_slave.sel), .q(stage1)
  );
  // Next state: one response per stb assertion, then wait in HOLD for stb to drop
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:               if (bus_slave.stb) state_nxt = bad ? RESP_ERR : (!bus_slave.we && OutReg) ? RD_WAIT : RESP_ACK;
      RD_WAIT:            state_nxt = RESP_ACK;
      RESP_ACK, RESP_ERR: state_nxt = HOLD;
      HOLD:               if (!bus_slave.stb) state_nxt = IDLE;
      default:            state_nxt = IDLE;
    endcase
  end
  // State and registered response strobes derived from the upcoming state
  always_ff @(posedge clk_in or posedge reset_in)
    if (reset_in) begin
      state <= IDLE;
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      ack_q <= state_nxt == RESP_ACK;
      err_q <= state_nxt == RESP_ERR;
    end
  if (OutReg) begin : g_out
    logic [WB_DATA_W-1:0] rdata_q;
    // Second read stage loaded from stage 1 while waiting
    always_ff @(posedge clk_in or posedge reset_in)
      if (reset_in) rdata_q <= '0;
      else if (state == RD_WAIT) rdata_q <= stage1;
    assign bus_slave.rdata = rdata_q;
  end else begin : g_direct
    assign bus_slave.rdata = stage1;
  end
endmodule

// File: tb/tb_wb_memory.sv
// tb_wb_memory: directed table-driven checks of three wb_memory configurations
module tb_wb_memory;
  logic clk = 1'b0;
  logic reset_in = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0] sel = '0;
  logic we = 1'b0;
  logic [2:0] stb = '0;
  logic [2:0] ack_v, err_v;
  logic [31:0] rdata_v [3];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_bus b0();
  wb_bus b1();
  wb_bus b2();
  assign b0.addr = addr;
  assign b0.wdata = wdata;
  assign b0.sel = sel;
  assign b0.we = we;
  assign b0.stb = stb[0];
  assign b1.addr = addr;
  assign b1.wdata = wdata;
  assign b1.sel = sel;
  assign b1.we = we;
  assign b1.stb = stb[1];
  assign b2.addr = addr;
  assign b2.wdata = wdata;
  assign b2.sel = sel;
  assign b2.we = we;
  assign b2.stb = stb[2];
  assign ack_v = {b2.ack, b1.ack, b0.ack};
  assign err_v = {b2.err, b1.err, b0.err};
  assign rdata_v[0] = b0.rdata;
  assign rdata_v[1] = b1.rdata;
  assign rdata_v[2] = b2.rdata;

  wb_memory #(.BaseAddr(32'h0), .ReadOnly(1'b1), .OutReg(1'b0)) dut0 (
    .clk_in(clk), .reset_in(reset_in), .bus_slave(b0));
  wb_memory #(.BaseAddr(32'h1000_0000), .ReadOnly(1'b0), .OutReg(1'b0)) dut1 (
    .clk_in(clk), .reset_in(reset_in), .bus_slave(b1));
  wb_memory #(.BaseAddr(32'h0), .ReadOnly(1'b0), .OutReg(1'b1)) dut2 (
    .clk_in(clk), .reset_in(reset_in), .bus_slave(b2));

  typedef struct {
    int d;
    logic w;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0] s;
    int ack_at;
    int err_at;
    logic chk_rd;
    logic [31:0] rd;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] s, output int ack_n, output int ack_at, output int err_n,
                     output int err_at, output logic [31:0] rd);
    ack_n = 0; ack_at = 0; err_n = 0; err_at = 0; rd = 'x;
    @(negedge clk);
    addr = a; wdata = wd; sel = s; we = w; stb[d] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (ack_v[d]) begin
        if (ack_n == 0) ack_at = k;
        ack_n++;
        rd = rdata_v[d];
      end
      if (err_v[d]) begin
        if (err_n == 0) err_at = k;
        err_n++;
      end
      if (k == 1) begin
        addr = ~a; we = ~w; sel = ~s;
      end
      if (k == 4) stb[d] = 1'b0;
    end
  endtask

  task automatic count_resp(input int d, input int cycles, output int ack_n, output int err_n);
    ack_n = 0; err_n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      #1;
      ack_n += int'(ack_v[d]);
      err_n += int'(err_v[d]);
    end
  endtask

  initial begin
    vec_t v[$];
    int an, aa, en, ea, ra, re_n;
    logic [31:0] rd;
    v.push_back('{0, 1'b0, 32'h0000_0008, 32'h0, 4'hF, 1, 0, 1'b1, 32'h0000_0013});
    v.push_back('{0, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 0, 1, 1'b0, 32'h0});
    v.push_back('{0, 1'b0, 32'h0000_0008, 32'h0, 4'hF, 1, 0, 1'b1, 32'h0000_0013});
    v.push_back('{0, 1'b0, 32'h0000_0002, 32'h0, 4'hF, 0, 1, 1'b0, 32'h0});
    v.push_back('{0, 1'b0, 32'h0000_1000, 32'h0, 4'hF, 0, 1, 1'b0, 32'h0});
    v.push_back('{0, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF, 0, 1, 1'b0, 32'h0});
    v.push_back('{1, 1'b1, 32'h1000_0010, 32'hAABB_CCDD, 4'b0101, 1, 0, 1'b0, 32'h0});
    v.push_back('{1, 1'b0, 32'h1000_0010, 32'h0, 4'hF, 1, 0, 1'b1, 32'h00BB_00DD});
    v.push_back('{1, 1'b1, 32'h1000_0010, 32'h1111_1111, 4'h0, 0, 1, 1'b0, 32'h0});
    v.push_back('{1, 1'b1, 32'h1000_0012, 32'h2222_2222, 4'hF, 0, 1, 1'b0, 32'h0});
    v.push_back('{1, 1'b1, 32'h1000_1000, 32'h3333_3333, 4'hF, 0, 1, 1'b0, 32'h0});
    v.push_back('{1, 1'b0, 32'h0FFF_FFFC, 32'h0, 4'hF, 0, 1, 1'b0, 32'h0});
    v.push_back('{1, 1'b0, 32'h1000_0010, 32'h0, 4'hF, 1, 0, 1'b1, 32'h00BB_00DD});
    v.push_back('{1, 1'b1, 32'h1000_0014, 32'h1234_5678, 4'hF, 1, 0, 1'b0, 32'h0});
    v.push_back('{1, 1'b0, 32'h1000_0014, 32'h0, 4'hF, 1, 0, 1'b1, 32'h1234_5678});
    v.push_back('{2, 1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 1, 0, 1'b0, 32'h0});
    v.push_back('{2, 1'b1, 32'h0000_0FFC, 32'h0BAD_BEEF, 4'hF, 1, 0, 1'b0, 32'h0});
    v.push_back('{2, 1'b0, 32'h0000_0000, 32'h0, 4'hF, 2, 0, 1'b1, 32'hCAFE_F00D});
    v.push_back('{2, 1'b0, 32'h0000_0FFC, 32'h0, 4'hF, 2, 0, 1'b1, 32'h0BAD_BEEF});
    v.push_back('{2, 1'b1, 32'h0000_0000, 32'hFF00_0000, 4'b1000, 1, 0, 1'b0, 32'h0});
    v.push_back('{2, 1'b0, 32'h0000_0000, 32'h0, 4'hF, 2, 0, 1'b1, 32'hFFFE_F00D});
    v.push_back('{2, 1'b0, 32'h0000_1000, 32'h0, 4'hF, 0, 1, 1'b0, 32'h0});

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset d%0d ack", d), 32'(ack_v[d]), 32'h0);
      chk($sformatf("reset d%0d err", d), 32'(err_v[d]), 32'h0);
      chk($sformatf("reset d%0d rdata", d), rdata_v[d], 32'h0);
    end
    @(negedge clk);
    reset_in = 1'b0;

    for (int i = 0; i < v.size(); i++) begin
      txn(v[i].d, v[i].w, v[i].a, v[i].wd, v[i].s, an, aa, en, ea, rd);
      chk($sformatf("v%0d ack count", i), 32'(an), 32'(v[i].ack_at != 0));
      chk($sformatf("v%0d ack latency", i), 32'(aa), 32'(v[i].ack_at));
      chk($sformatf("v%0d err count", i), 32'(en), 32'(v[i].err_at != 0));
      chk($sformatf("v%0d err latency", i), 32'(ea), 32'(v[i].err_at));
      if (v[i].chk_rd) chk($sformatf("v%0d rdata", i), rd, v[i].rd);
    end

    @(negedge clk);
    addr = 32'h4; we = 1'b0; sel = 4'hF; stb[0] = 1'b1;
    count_resp(0, 6, ra, re_n);
    chk("held stb ack count", 32'(ra), 32'd1);
    chk("held stb err count", 32'(re_n), 32'd0);
    stb[0] = 1'b0;
    @(posedge clk);
    #1;
    stb[0] = 1'b1;
    count_resp(0, 3, ra, re_n);
    chk("re-raised stb ack count", 32'(ra), 32'd1);
    stb[0] = 1'b0;
    repeat (2) @(posedge clk);

    @(negedge clk);
    addr = 32'h0; we = 1'b0; sel = 4'hF; stb[2] = 1'b1;
    @(posedge clk);
    #3;
    reset_in = 1'b1;
    #1;
    chk("mid-read reset ack", 32'(ack_v[2]), 32'h0);
    chk("mid-read reset err", 32'(err_v[2]), 32'h0);
    chk("mid-read reset rdata", rdata_v[2], 32'h0);
    stb[2] = 1'b0;
    @(posedge clk);
    #1;
    reset_in = 1'b0;
    count_resp(2, 4, ra, re_n);
    chk("post-reset stray ack", 32'(ra), 32'd0);
    chk("post-reset stray err", 32'(re_n), 32'd0);
    txn(2, 1'b0, 32'h0000_0FFC, 32'h0, 4'hF, an, aa, en, ea, rd);
    chk("post-reset read ack latency", 32'(aa), 32'd2);
    chk("post-reset read ack count", 32'(an), 32'd1);
    chk("post-reset read rdata", rd, 32'h0BAD_BEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
